band_peak_meter: RTL and testbench
==================================

Name: band_peak_meter

Overview:
Downstream consumer of the 7-band magnitude data produced by the left and right frequency-analysis stages. On each audio sample strobe it combines the L/R band levels into one stereo level per band. It also maintains a per-band peak with hold and linear decay. It presents atomically updated level/peak vectors to the display and mixer logic.

Parameters:
W, 8, band level width in bits
NBANDS, 7, number of frequency bands
FRAME_DIV, 800, accepted ready strobes per display frame (48 kHz / 800 = 60 Hz)
HOLD_FRAMES, 30, frames a new peak is held before decay starts
DECAY_STEP, 2, amount subtracted from a peak per frame once its hold expires

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ready  in  1  one-cycle sample strobe, same strobe that drives the frequency stages
l_levels  in  NBANDS*W  left band levels, band k at [W*k+W-1:W*k], band 0 = freq1
r_levels  in  NBANDS*W  right band levels, same packing
avg_mode  in  1  0 = combined level is max(L,R); 1 = (L+R)>>1
level_out  out  NBANDS*W  combined level per band, same packing
peak_out  out  NBANDS*W  held/decaying peak per band
meter_valid  out  1  one-cycle pulse when level_out/peak_out have just updated
busy  out  1  high while a scan is in progress
overrun  out  1  sticky flag: ready arrived while busy

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; state IDLE; all peaks, hold counters and the frame counter 0; shadow registers 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE: on ready, latch l_levels, r_levels and avg_mode into input registers. Set band index = 0, go to SCAN, busy = 1.
- Frame counting: each accepted ready increments frame_cnt. When frame_cnt == FRAME_DIV-1 on acceptance, frame_cnt wraps to 0 and frame_tick is set for that scan only.
- SCAN: one band per cycle, index 0..NBANDS-1, so 7 cycles.
  - Combine: c = max(L,R), or (L+R)>>1 with a W+1-bit sum, never saturating.
  - Shadow level[k] = c.
  - If c >= peak[k]: peak[k] = c, hold[k] = HOLD_FRAMES. This applies on every scan, frame tick or not.
  - Else if frame_tick and hold[k] != 0: hold[k] -= 1.
  - Else if frame_tick and hold[k] == 0: peak[k] = (peak[k] > DECAY_STEP) ? peak[k]-DECAY_STEP : 0. Decay clamps to 0 and never wraps.
  - After band NBANDS-1, go to DONE.
- DONE (one cycle): copy shadow levels and peaks to level_out/peak_out. meter_valid = 1 for this cycle only. busy = 0 at the next cycle. Return to IDLE.
- Latency: ready accepted in cycle 0; SCAN occupies cycles 1..7; meter_valid is high in cycle 8; outputs change in cycle 8 and hold until the next DONE.
- Outputs never show a partially updated scan.
- ready while busy (SCAN or DONE):
  - the strobe is dropped;
  - inputs are not latched;
  - frame_cnt does not increment;
  - overrun is set and stays 1 until reset.
- ready in the same cycle as the DONE→IDLE transition is dropped. Only IDLE accepts.
- Reset asserted mid-scan: immediate return to the reset state. No meter_valid is produced for the aborted scan.
- Hold counter width: clog2(HOLD_FRAMES+1). Frame counter width: clog2(FRAME_DIV).

Decomposition:
- Shared audio package holds:
  - band count and level width constants (NBANDS=7, W=8), reused by the frequency stages;
  - the FSM state encoding;
  - the packing convention (band k slice).
- One sub-module is natural: band_peak_cell. It is purely combinational: it takes c, peak, hold and frame_tick and returns next peak and next hold. The top holds the FSM, counters and register arrays, and instantiates one cell, time-multiplexed by band index.

Test Plan:
All scenarios use overridden parameters FRAME_DIV=4, HOLD_FRAMES=2, DECAY_STEP=2.
- Reset then a single ready, with avg_mode=0, L band0=0x40, R band0=0x60, all other bands 0 → meter_valid exactly 8 cycles after ready; level band0=0x60, peak band0=0x60, other bands 0.
- avg_mode=1, L=0xFF, R=0xFF on band6 → level band6=0xFF (no overflow). L=0xFF, R=0x00 → level 0x7F.
- Peak hold/decay on band0:
  - drive 0x50 once, then 0x00 for 20 readies;
  - peak stays 0x50 through 2 frame ticks after capture, then 0x4E, 0x4C, ... once per frame;
  - a new input 0x60 mid-decay restores the peak to 0x60 and reloads the hold.
- Decay clamp: peak 0x03, input 0 → after hold expires, peak 0x01 then 0x00, and stays 0x00 (no wrap).
- ready pulsed 3 cycles after an accepted ready → dropped; overrun=1; only one meter_valid; frame_cnt advanced once. overrun stays 1 until reset.
- reset pulled low during SCAN cycle 4 → all outputs 0 immediately; no meter_valid. After release, the next ready completes normally.

Source files
------------

// File: rtl/band_peak_meter_pkg.sv
// Shared audio constants for the band analysis chain and the peak meter FSM encoding.
// Band k of any packed level vector lives at [W*k +: W], band 0 = freq1.
package band_peak_meter_pkg;

  localparam int BAND_COUNT = 7;
  localparam int LEVEL_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int band_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/band_peak_cell.sv
// Per-band peak update: capture on new max, otherwise count down hold then decay per frame.
module band_peak_cell #(
  parameter int W           = 8,
  parameter int HW          = 5,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY_STEP  = 2
) (
  input  logic [W-1:0]  c,
  input  logic [W-1:0]  peak,
  input  logic [HW-1:0] hold,
  input  logic          frame_tick,
  output logic [W-1:0]  peak_nxt,
  output logic [HW-1:0] hold_nxt
);

  always_comb begin
    peak_nxt = peak;
    hold_nxt = hold;
    if (c >= peak) begin
      peak_nxt = c;
      hold_nxt = HW'(HOLD_FRAMES);
    end else if (frame_tick) begin
      if (hold != '0)
        hold_nxt = hold - 1'b1;
      else if (peak > W'(DECAY_STEP))
        peak_nxt = peak - W'(DECAY_STEP);
      else
        peak_nxt = '0;
    end
  end

endmodule

// File: rtl/band_peak_meter.sv
// Stereo band level combiner with per-band peak hold/decay; one shared cell walks the bands
// and results are published atomically when the scan completes.
module band_peak_meter
  import band_peak_meter_pkg::*;
#(
  parameter int W           = LEVEL_W,
  parameter int NBANDS      = BAND_COUNT,
  parameter int FRAME_DIV   = 800,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY_STEP  = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ready,
  input  logic [NBANDS*W-1:0] l_levels,
  input  logic [NBANDS*W-1:0] r_levels,
  input  logic                avg_mode,
  output logic [NBANDS*W-1:0] level_out,
  output logic [NBANDS*W-1:0] peak_out,
  output logic                meter_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int IW = (NBANDS > 1) ? $clog2(NBANDS) : 1;

  state_e state, state_nxt;

  logic [NBANDS-1:0][W-1:0]  l_q, r_q;
  logic [NBANDS-1:0][W-1:0]  shadow, peak_q;
  logic [NBANDS-1:0][W-1:0]  level_q, pk_out_q;
  logic [NBANDS-1:0][W-1:0]  shadow_upd, peak_upd;
  logic [NBANDS-1:0][HW-1:0] hold_q;
  logic                      avg_q;
  logic [IW-1:0]             idx;
  logic [FW-1:0]             frame_cnt;
  logic                      frame_tick;
  logic                      overrun_q;

  logic          accept, last;
  logic [W-1:0]  l_sel, r_sel, c;
  logic [W:0]    sum;
  logic [W-1:0]  peak_nxt;
  logic [HW-1:0] hold_nxt;

  assign l_sel = l_q[idx];
  assign r_sel = r_q[idx];
  // W+1-bit sum keeps the average exact for full-scale inputs.
  assign sum   = {1'b0, l_sel} + {1'b0, r_sel};
  assign c     = avg_q ? sum[W:1] : ((l_sel > r_sel) ? l_sel : r_sel);
  assign last  = (idx == IW'(NBANDS - 1));

  band_peak_cell #(
    .W           (W),
    .HW          (HW),
    .HOLD_FRAMES (HOLD_FRAMES),
    .DECAY_STEP  (DECAY_STEP)
  ) u_cell (
    .c          (c),
    .peak       (peak_q[idx]),
    .hold       (hold_q[idx]),
    .frame_tick (frame_tick),
    .peak_nxt   (peak_nxt),
    .hold_nxt   (hold_nxt)
  );

  // Final band merged in so the outputs load on the edge into DONE.
  always_comb begin
    shadow_upd      = shadow;
    peak_upd        = peak_q;
    shadow_upd[idx] = c;
    peak_upd[idx]   = peak_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (ready) begin
        accept    = 1'b1;
        state_nxt = SCAN;
      end
      SCAN:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      l_q        <= '0;
      r_q        <= '0;
      avg_q      <= 1'b0;
      idx        <= '0;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
      overrun_q  <= 1'b0;
      shadow     <= '0;
      peak_q     <= '0;
      hold_q     <= '0;
      level_q    <= '0;
      pk_out_q   <= '0;
    end else begin
      if (ready && state != IDLE) overrun_q <= 1'b1;
      if (accept) begin
        l_q   <= l_levels;
        r_q   <= r_levels;
        avg_q <= avg_mode;
        idx   <= '0;
        if (frame_cnt == FW'(FRAME_DIV - 1)) begin
          frame_cnt  <= '0;
          frame_tick <= 1'b1;
        end else begin
          frame_cnt  <= frame_cnt + 1'b1;
          frame_tick <= 1'b0;
        end
      end
      if (state == SCAN) begin
        shadow[idx] <= c;
        peak_q[idx] <= peak_nxt;
        hold_q[idx] <= hold_nxt;
        idx         <= idx + 1'b1;
        if (last) begin
          level_q  <= shadow_upd;
          pk_out_q <= peak_upd;
        end
      end
    end
  end

  assign level_out   = level_q;
  assign peak_out    = pk_out_q;
  assign meter_valid = (state == DONE);
  assign busy        = (state != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_band_peak_meter.sv
// Scoreboard bench for band_peak_meter with short frames (FRAME_DIV=4, HOLD=2, STEP=2).
module tb_band_peak_meter;
  import band_peak_meter_pkg::*;

  localparam int NB = 7;
  localparam int W  = 8;
  localparam int FD = 4;
  localparam int HF = 2;
  localparam int DS = 2;

  typedef struct {
    logic [NB*W-1:0] lvl;
    logic [NB*W-1:0] pk;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            ready = 1'b0;
  logic [NB*W-1:0] l_levels = '0;
  logic [NB*W-1:0] r_levels = '0;
  logic            avg_mode = 1'b0;
  logic [NB*W-1:0] level_out, peak_out;
  logic            meter_valid, busy, overrun;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   mv_count = 0;
  exp_t exp_q[$];

  logic [W-1:0] m_pk[NB];
  int           m_hd[NB];
  int           m_fcnt;

  band_peak_meter #(
    .W(W), .NBANDS(NB), .FRAME_DIV(FD), .HOLD_FRAMES(HF), .DECAY_STEP(DS)
  ) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .l_levels(l_levels), .r_levels(r_levels), .avg_mode(avg_mode),
    .level_out(level_out), .peak_out(peak_out),
    .meter_valid(meter_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [NB*W-1:0] band(input int k, input logic [W-1:0] v);
    logic [NB*W-1:0] t;
    t = '0;
    t[band_lsb(k, W) +: W] = v;
    return t;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NB; k++) begin
      m_pk[k] = '0;
      m_hd[k] = 0;
    end
    m_fcnt = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic [NB*W-1:0] l, input logic [NB*W-1:0] r, input logic avg);
    exp_t e;
    bit   tick;
    int   lv, rv, cv;
    tick = (m_fcnt == FD - 1);
    m_fcnt = tick ? 0 : m_fcnt + 1;
    for (int k = 0; k < NB; k++) begin
      lv = int'(l[k*W +: W]);
      rv = int'(r[k*W +: W]);
      cv = avg ? (lv + rv) / 2 : ((lv > rv) ? lv : rv);
      e.lvl[k*W +: W] = W'(cv);
      if (cv >= int'(m_pk[k])) begin
        m_pk[k] = W'(cv);
        m_hd[k] = HF;
      end else if (tick && m_hd[k] != 0) begin
        m_hd[k] = m_hd[k] - 1;
      end else if (tick) begin
        m_pk[k] = (int'(m_pk[k]) > DS) ? W'(int'(m_pk[k]) - DS) : '0;
      end
      e.pk[k*W +: W] = m_pk[k];
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (meter_valid) begin
      exp_t e;
      mv_count++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard: unexpected meter_valid, level=%h peak=%h", level_out, peak_out);
      end else begin
        e = exp_q.pop_front();
        if (level_out !== e.lvl || peak_out !== e.pk)
          $display("FAIL scoreboard: level=%h peak=%h expected level=%h peak=%h",
                   level_out, peak_out, e.lvl, e.pk);
        else
          pass_cnt++;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // One accepted strobe; checks meter_valid arrives in cycle 8 after the strobe cycle.
  task automatic scan(input logic [NB*W-1:0] l, input logic [NB*W-1:0] r, input logic avg);
    int n;
    @(negedge clock);
    l_levels = l;
    r_levels = r;
    avg_mode = avg;
    ready    = 1'b1;
    model_push(l, r, avg);
    @(negedge clock);
    ready = 1'b0;
    n = 1;
    while (!meter_valid && n < 30) begin
      @(negedge clock);
      n++;
    end
    total_cnt++;
    if (!meter_valid || n != 8)
      $display("FAIL latency: meter_valid seen at cycle %0d (valid=%b), expected cycle 8", n, meter_valid);
    else
      pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    repeat (3) @(negedge clock);
    total_cnt++;
    if ({level_out, peak_out, meter_valid, busy, overrun} !== '0)
      $display("FAIL reset_state: level=%h peak=%h mv=%b busy=%b ovr=%b expected all 0",
               level_out, peak_out, meter_valid, busy, overrun);
    else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    scan(band(0, 8'h40), band(0, 8'h60), 1'b0);
    total_cnt++;
    if (level_out !== band(0, 8'h60)) $display("FAIL basic_level: got %h expected %h", level_out, band(0, 8'h60));
    else pass_cnt++;
    total_cnt++;
    if (peak_out !== band(0, 8'h60)) $display("FAIL basic_peak: got %h expected %h", peak_out, band(0, 8'h60));
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || overrun !== 1'b0) $display("FAIL basic_flags: busy=%b ovr=%b expected 0 0", busy, overrun);
    else pass_cnt++;
  endtask

  task automatic test_avg();
    scan(band(6, 8'hFF), band(6, 8'hFF), 1'b1);
    total_cnt++;
    if (level_out[6*W +: W] !== 8'hFF) $display("FAIL avg_full: got %h expected ff", level_out[6*W +: W]);
    else pass_cnt++;
    scan(band(6, 8'hFF), '0, 1'b1);
    total_cnt++;
    if (level_out[6*W +: W] !== 8'h7F) $display("FAIL avg_half: got %h expected 7f", level_out[6*W +: W]);
    else pass_cnt++;
  endtask

  task automatic test_hold_decay();
    logic [W-1:0] pk[40];
    apply_reset();
    scan(band(0, 8'h50), '0, 1'b0);
    pk[1] = peak_out[W-1:0];
    for (int s = 2; s <= 21; s++) begin
      scan('0, '0, 1'b0);
      pk[s] = peak_out[W-1:0];
    end
    scan(band(0, 8'h60), '0, 1'b0);
    pk[22] = peak_out[W-1:0];
    for (int s = 23; s <= 32; s++) begin
      scan('0, '0, 1'b0);
      pk[s] = peak_out[W-1:0];
    end
    total_cnt++;
    if (pk[11] !== 8'h50) $display("FAIL hold_before_decay: got %h expected 50", pk[11]); else pass_cnt++;
    total_cnt++;
    if (pk[12] !== 8'h4E) $display("FAIL first_decay: got %h expected 4e", pk[12]); else pass_cnt++;
    total_cnt++;
    if (pk[16] !== 8'h4C) $display("FAIL second_decay: got %h expected 4c", pk[16]); else pass_cnt++;
    total_cnt++;
    if (pk[21] !== 8'h4A) $display("FAIL third_decay: got %h expected 4a", pk[21]); else pass_cnt++;
    total_cnt++;
    if (pk[22] !== 8'h60) $display("FAIL recapture: got %h expected 60", pk[22]); else pass_cnt++;
    total_cnt++;
    if (pk[31] !== 8'h60) $display("FAIL hold_reload: got %h expected 60", pk[31]); else pass_cnt++;
    total_cnt++;
    if (pk[32] !== 8'h5E) $display("FAIL decay_after_reload: got %h expected 5e", pk[32]); else pass_cnt++;
  endtask

  task automatic test_clamp();
    logic [W-1:0] pk[21];
    apply_reset();
    scan(band(3, 8'h03), '0, 1'b0);
    pk[1] = peak_out[3*W +: W];
    for (int s = 2; s <= 20; s++) begin
      scan('0, '0, 1'b0);
      pk[s] = peak_out[3*W +: W];
    end
    total_cnt++;
    if (pk[11] !== 8'h03) $display("FAIL clamp_hold: got %h expected 03", pk[11]); else pass_cnt++;
    total_cnt++;
    if (pk[12] !== 8'h01) $display("FAIL clamp_step: got %h expected 01", pk[12]); else pass_cnt++;
    total_cnt++;
    if (pk[16] !== 8'h00) $display("FAIL clamp_zero: got %h expected 00", pk[16]); else pass_cnt++;
    total_cnt++;
    if (pk[20] !== 8'h00) $display("FAIL clamp_no_wrap: got %h expected 00", pk[20]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int mv0;
    apply_reset();
    mv0 = mv_count;
    @(negedge clock);
    l_levels = band(0, 8'h10);
    r_levels = '0;
    avg_mode = 1'b0;
    ready    = 1'b1;
    model_push(band(0, 8'h10), '0, 1'b0);
    @(negedge clock);
    ready = 1'b0;
    repeat (2) @(negedge clock);
    ready    = 1'b1;
    l_levels = band(0, 8'hAA);
    @(negedge clock);
    ready    = 1'b0;
    l_levels = '0;
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: got %b expected 1", overrun); else pass_cnt++;
    repeat (14) @(negedge clock);
    total_cnt++;
    if (mv_count - mv0 != 1) $display("FAIL single_valid: got %0d pulses expected 1", mv_count - mv0);
    else pass_cnt++;
    for (int s = 2; s <= 12; s++) scan('0, '0, 1'b0);
    total_cnt++;
    if (peak_out[W-1:0] !== 8'h0E) $display("FAIL frame_cnt_once: peak %h expected 0e", peak_out[W-1:0]);
    else pass_cnt++;
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", overrun); else pass_cnt++;
    apply_reset();
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b expected 0", overrun); else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan();
    scan(band(2, 8'h33), band(2, 8'h21), 1'b0);
    @(negedge clock);
    l_levels = band(2, 8'h77);
    ready    = 1'b1;
    model_push(band(2, 8'h77), '0, 1'b0);
    repeat (4) begin
      @(negedge clock);
      ready = 1'b0;
    end
    reset = 1'b0;
    #1;
    model_clear();
    total_cnt++;
    if ({level_out, peak_out, meter_valid, busy} !== '0)
      $display("FAIL abort_clear: level=%h peak=%h mv=%b busy=%b expected all 0",
               level_out, peak_out, meter_valid, busy);
    else pass_cnt++;
    repeat (6) begin
      @(negedge clock);
      total_cnt++;
      if (meter_valid !== 1'b0) $display("FAIL abort_no_valid: got %b expected 0", meter_valid);
      else pass_cnt++;
    end
    reset = 1'b1;
    scan(band(1, 8'h22), band(1, 8'h11), 1'b0);
    total_cnt++;
    if (level_out !== band(1, 8'h22)) $display("FAIL after_abort: got %h expected %h", level_out, band(1, 8'h22));
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_avg();
    test_hold_decay();
    test_clamp();
    test_back_to_back();
    test_reset_mid_scan();
    repeat (3) @(negedge clock);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
